// File: rtl/sym_dn_lut_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sym_dn_lut_pipe_pkg
//  Description : Shared constants for the symbol-node LUT read pipeline:
//                default message width / port count and the load-FSM state
//                encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sym_dn_lut_pipe_pkg;

    // Default message width and number of read ports
    localparam int QUAN_SIZE_DEF = 4;
    localparam int PORT_NUM_DEF  = 2;

    // Load FSM state encoding
    localparam int              c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_LOAD  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_READY = 2'd2;

endpackage : sym_dn_lut_pipe_pkg
`default_nettype wire

// File: rtl/sym_dn_fold.sv
`default_nettype none
// ============================================================================
//  Module      : sym_dn_fold
//  Description : Combinational sign fold for one read port. Folds the sign of
//                y0 into its magnitude, optionally transposes, conditionally
//                inverts y1 and builds the LUT address.
//  Ports       : y0_i, y1_i        - incoming messages (QUAN_SIZE bits)
//                transpose_en_i    - sign transpose enable
//                offset_i          - table select (address MSB)
//                addr_o            - LUT address (2*QUAN_SIZE bits)
//                msb_eff_o         - effective sign, re-applied after lookup
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_dn_fold #(
    parameter int QUAN_SIZE = 4
) (
    input  logic [QUAN_SIZE-1:0]   y0_i,
    input  logic [QUAN_SIZE-1:0]   y1_i,
    input  logic                   transpose_en_i,
    input  logic                   offset_i,
    output logic [2*QUAN_SIZE-1:0] addr_o,
    output logic                   msb_eff_o
);

    logic [QUAN_SIZE-2:0] w_y0m;
    logic [QUAN_SIZE-1:0] w_y1m;

    // The y0 magnitude fold uses the raw y0 sign, not the transposed one;
    // only the y1 inversion and the final output flip follow msb_eff.
    assign msb_eff_o = y0_i[QUAN_SIZE-1] ^ transpose_en_i;
    assign w_y0m     = y0_i[QUAN_SIZE-2:0] ^ {(QUAN_SIZE-1){y0_i[QUAN_SIZE-1]}};
    assign w_y1m     = msb_eff_o ? ~y1_i : y1_i;
    assign addr_o    = {offset_i, w_y0m, w_y1m};

endmodule : sym_dn_fold
`default_nettype wire

// File: rtl/sym_dn_lut_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sym_dn_lut_pipe
//  Description : Multi-port hard-decision lookup. A 1-bit-wide table of
//                2^(2*QUAN_SIZE) entries is loaded serially, then read by
//                PORT_NUM independent 3-stage pipelines (fold -> lookup ->
//                sign re-apply), full throughput, no stall.
//  Ports       : read_clk          - clock for pipeline, load and storage
//                rstn              - asynchronous active-low reset
//                in_valid          - per-port request strobe
//                transpose_en      - per-port sign transpose enable
//                y0_in, y1_in      - packed per-port messages
//                read_addr_offset  - table select shared by all ports
//                load_start        - pulse starting a full table reload
//                load_valid        - qualifies load_bit
//                load_bit          - serial table data, ascending address
//                lut_ready         - table complete, requests accepted
//                out_valid         - per-port result strobe
//                t_c               - per-port hard decision
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_dn_lut_pipe
    import sym_dn_lut_pipe_pkg::*;
#(
    parameter int QUAN_SIZE = QUAN_SIZE_DEF,
    parameter int PORT_NUM  = PORT_NUM_DEF
) (
    input  logic                          read_clk,
    input  logic                          rstn,
    input  logic [PORT_NUM-1:0]           in_valid,
    input  logic [PORT_NUM-1:0]           transpose_en,
    input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
    input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
    input  logic                          read_addr_offset,
    input  logic                          load_start,
    input  logic                          load_valid,
    input  logic                          load_bit,
    output logic                          lut_ready,
    output logic [PORT_NUM-1:0]           out_valid,
    output logic [PORT_NUM-1:0]           t_c
);

    localparam int               c_AW        = 2 * QUAN_SIZE;
    localparam int               LUT_DEPTH   = 1 << c_AW;
    localparam logic [c_AW-1:0]  c_CNT_ONE   = c_AW'(1);
    localparam logic [c_AW-1:0]  c_CNT_LAST  = '1;

    // ------------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------------
    logic [c_ST_W-1:0] state_q, state_d;
    logic [c_AW-1:0]   cnt_q,   cnt_d;
    logic              w_lut_we;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // load_start wins over load_valid in the same cycle: the restart takes
    // effect and nothing is written. The terminal write jumps to READY, so
    // the counter never wraps back onto written entries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_ST_IDLE: begin
                if (load_start) begin
                    state_d = c_ST_LOAD;
                    cnt_d   = '0;
                end
            end
            c_ST_LOAD: begin
                if (load_start) begin
                    cnt_d = '0;
                end else if (load_valid) begin
                    if (cnt_q == c_CNT_LAST) begin
                        state_d = c_ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_CNT_ONE;
                    end
                end
            end
            c_ST_READY: begin
                if (load_start) begin
                    state_d = c_ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lut_ready = (state_q == c_ST_READY);
        w_lut_we  = (state_q == c_ST_LOAD) && load_valid && !load_start;
    end

    // ------------------------------------------------------------------------
    // Table storage: one write port, asynchronous reads, deliberately not
    // reset so it maps onto distributed RAM.
    // ------------------------------------------------------------------------
    logic lut_q [LUT_DEPTH];

    always_ff @(posedge read_clk) begin
        if (w_lut_we) begin
            lut_q[cnt_q] <= load_bit;
        end
    end

    // ------------------------------------------------------------------------
    // Per-port read pipelines
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        logic [c_AW-1:0] w_fold_addr;
        logic            w_fold_msb;

        // Stage 0 keeps the whole address; it is exactly
        // {offset, y0m, y1m}, so nothing is lost by storing it packed.
        logic [c_AW-1:0] s0_addr_q;
        logic            s0_msb_q;
        logic            s0_vld_q;
        logic            s1_bit_q;
        logic            s1_msb_q;
        logic            s1_vld_q;
        logic            s2_tc_q;
        logic            s2_vld_q;

        sym_dn_fold #(
            .QUAN_SIZE (QUAN_SIZE)
        ) u_fold (
            .y0_i           (y0_in[p*QUAN_SIZE +: QUAN_SIZE]),
            .y1_i           (y1_in[p*QUAN_SIZE +: QUAN_SIZE]),
            .transpose_en_i (transpose_en[p]),
            .offset_i       (read_addr_offset),
            .addr_o         (w_fold_addr),
            .msb_eff_o      (w_fold_msb)
        );

        always_ff @(posedge read_clk or negedge rstn) begin
            if (!rstn) begin
                s0_addr_q <= '0;
                s0_msb_q  <= 1'b0;
                s0_vld_q  <= 1'b0;
                s1_bit_q  <= 1'b0;
                s1_msb_q  <= 1'b0;
                s1_vld_q  <= 1'b0;
                s2_tc_q   <= 1'b0;
                s2_vld_q  <= 1'b0;
            end else begin
                s0_addr_q <= w_fold_addr;
                s0_msb_q  <= w_fold_msb;
                s0_vld_q  <= in_valid[p] && lut_ready;

                s1_bit_q  <= lut_q[s0_addr_q];
                s1_msb_q  <= s0_msb_q;
                s1_vld_q  <= s0_vld_q;

                s2_vld_q  <= s1_vld_q;
                // Result only moves on a valid beat; otherwise it holds.
                if (s1_vld_q) begin
                    s2_tc_q <= s1_bit_q ^ s1_msb_q;
                end
            end
        end

        assign out_valid[p] = s2_vld_q;
        assign t_c[p]       = s2_tc_q;
    end : g_port

endmodule : sym_dn_lut_pipe
`default_nettype wire

// File: doc/sym_dn_lut_pipe.md
SYM_DN_LUT_PIPE -- requirements
Module: sym_dn_lut_pipe

Interface
REQ-001 Parameter QUAN_SIZE, default 4, bit width of each incoming message y0/y1.
REQ-002 Parameter PORT_NUM, default 2, number of independent read ports.
REQ-003 Parameter LUT_DEPTH, derived, 2^(2*QUAN_SIZE) one-bit entries (offset bit + (QUAN_SIZE-1) y0 magnitude bits + QUAN_SIZE y1 bits).
REQ-004 read_clk  input  1  single clock for read pipeline, LUT load and storage.
REQ-005 rstn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 in_valid  input  PORT_NUM  per-port request strobe.
REQ-007 transpose_en  input  PORT_NUM  per-port sign transpose enable.
REQ-008 y0_in  input  PORT_NUM*QUAN_SIZE  packed first message per port, port p at bits [p*QUAN_SIZE +: QUAN_SIZE].
REQ-009 y1_in  input  PORT_NUM*QUAN_SIZE  packed second message per port, same packing.
REQ-010 read_addr_offset  input  1  table select, shared by all ports.
REQ-011 load_start  input  1  one-cycle pulse starting a full LUT reload.
REQ-012 load_valid  input  1  qualifies load_bit.
REQ-013 load_bit  input  1  serial LUT data, ascending address order.
REQ-014 lut_ready  output  1  LUT fully loaded, reads accepted.
REQ-015 out_valid  output  PORT_NUM  per-port result strobe.
REQ-016 t_c  output  PORT_NUM  per-port hard-decision result.

Function
REQ-017 Per port: msb_eff = y0[Q-1] ^ transpose_en; y0m = y0[Q-2:0] ^ {Q-1{y0[Q-1]}}; y1m = msb_eff ? ~y1 : y1.
REQ-018 LUT address = {read_addr_offset, y0m, y1m}, width 2*QUAN_SIZE.
REQ-019 Request accepted only when in_valid[p]=1 and lut_ready=1; otherwise ignored, no out_valid produced.
REQ-020 Stage 0 registers y0m, y1m, msb_eff, offset, valid; stage 1 registers LUT read bit, msb_eff, valid; stage 2 registers t_c[p] = lut_bit ^ msb_eff and out_valid[p].
REQ-021 Latency exactly 3 read_clk edges from accepted input to out_valid; full throughput, one request per port per cycle, no stall.
REQ-022 t_c[p] holds its last value when out_valid[p]=0.
REQ-023 Load FSM states: IDLE, LOAD, READY; IDLE->LOAD on load_start; READY->LOAD on load_start (lut_ready drops next cycle); LOAD->READY after write to address LUT_DEPTH-1.
REQ-024 In LOAD, each cycle with load_valid=1 writes load_bit at load counter and increments it; load_valid=0 holds counter.
REQ-025 load_start while in LOAD restarts counter at 0, state stays LOAD.
REQ-026 load_valid outside LOAD ignored, no write.
REQ-027 Requests in flight when lut_ready falls still complete with out_valid; their data may reflect partially reloaded table.
REQ-028 Counter width 2*QUAN_SIZE, never wraps: terminal write forces READY.

Reset
REQ-029 rstn low asynchronously clears: state IDLE, load counter 0, lut_ready 0, all pipeline valids 0, out_valid 0, t_c 0.
REQ-030 LUT storage not reset; contents undefined until a complete load.
REQ-031 Reset mid-LOAD abandons load; new load_start required.

Structure
REQ-032 Shared package holds load-FSM state encoding and default QUAN_SIZE/PORT_NUM constants.
REQ-033 One sub-module sym_dn_fold (REQ-017/018 per port, combinational), instantiated PORT_NUM times via generate.
REQ-034 LUT storage: single write port, PORT_NUM asynchronous read ports, inferred in this module.

Verification
REQ-035 Reset, load 256 bits with bit[a]=a[0] -> lut_ready=1 on cycle after 256th load_valid.
REQ-036 Port0 y0=0011,y1=0101,te=0,offset=0 -> addr 0x35, out_valid[0] after 3 cycles, t_c[0]=1.
REQ-037 Port1 y0=1011,y1=0101,te=0 -> y0m=100,y1m=1010,msb_eff=1, addr 0x4A, t_c[1]=0^1=1.
REQ-038 Requests while lut_ready=0 -> no out_valid pulses; back-to-back 10 requests after ready -> 10 consecutive out_valid.
REQ-039 load_start at count 100, then 256 writes -> READY only after 256 post-restart writes.
REQ-040 rstn asserted during pipeline full -> out_valid and t_c 0 immediately, lut_ready 0.
